// File: rtl/ember_ddr_arbiter_if.sv
// DDRAM Avalon-style master bus shared by the Ember core requesters.
// The master side is the arbiter; the slave side is the DDR controller (emu DDRAM_* ports).
interface ember_ddr_arbiter_if;
  localparam int unsigned ADDR_W  = 29;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BE_W    = 8;
  localparam int unsigned BURST_W = 8;

  logic               DDRAM_BUSY;
  logic [BURST_W-1:0] DDRAM_BURSTCNT;
  logic [ADDR_W-1:0]  DDRAM_ADDR;
  logic [DATA_W-1:0]  DDRAM_DOUT;
  logic               DDRAM_DOUT_READY;
  logic               DDRAM_RD;
  logic [DATA_W-1:0]  DDRAM_DIN;
  logic [BE_W-1:0]    DDRAM_BE;
  logic               DDRAM_WE;

  modport master (
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );

  modport slave (
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );
endinterface

// File: rtl/ember_ddr_arbiter.sv
// Two-port DDRAM arbiter: port A video read bursts, port B CPU single-beat read/write.
// Optional feature macro: EMBER_ARB_ROUNDROBIN_EN (alternate grants on contention).
module ember_ddr_arbiter #(
  parameter  int unsigned A_BURST = 8,
  localparam int unsigned ADDR_W  = 29,
  localparam int unsigned DATA_W  = 64,
  localparam int unsigned BE_W    = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  input  logic [BE_W-1:0]   b_be,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_done,
  output logic              DDRAM_CLK,
  ember_ddr_arbiter_if.master ddr
);
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned BURST_W = 8;
  localparam logic [CNT_W-1:0]   A_LAST    = CNT_W'(A_BURST - 1);
  localparam logic [BURST_W-1:0] A_BURSTCNT = BURST_W'(A_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_A_CMD, S_A_DATA, S_B_RD_CMD, S_B_RD_DATA, S_B_WR, S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d, we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [DATA_W-1:0]  a_dout_d, b_dout_d;
  logic               a_valid_d, a_done_d, b_done_d;
  logic               grant_a, grant_b;

`ifdef EMBER_ARB_ROUNDROBIN_EN
  // Cleared flag means B was granted last, so A wins the first contest.
  logic last_a_q;
  assign grant_a = a_req && (!b_req || !last_a_q);
`else
  assign grant_a = a_req;
`endif
  assign grant_b = b_req && !grant_a;

  assign DDRAM_CLK          = clk_sys;
  assign ddr.DDRAM_RD       = rd_q;
  assign ddr.DDRAM_WE       = we_q;
  assign ddr.DDRAM_ADDR     = addr_q;
  assign ddr.DDRAM_BURSTCNT = burst_q;
  assign ddr.DDRAM_DIN      = din_q;
  assign ddr.DDRAM_BE       = be_q;

  // State and output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      burst_q <= '0;
      din_q   <= '0;
      be_q    <= '0;
      a_dout  <= '0;
      a_valid <= 1'b0;
      a_done  <= 1'b0;
      b_dout  <= '0;
      b_done  <= 1'b0;
`ifdef EMBER_ARB_ROUNDROBIN_EN
      last_a_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      din_q   <= din_d;
      be_q    <= be_d;
      a_dout  <= a_dout_d;
      a_valid <= a_valid_d;
      a_done  <= a_done_d;
      b_dout  <= b_dout_d;
      b_done  <= b_done_d;
`ifdef EMBER_ARB_ROUNDROBIN_EN
      if (state_q == S_IDLE && (grant_a || grant_b)) last_a_q <= grant_a;
`endif
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a)      state_d = S_A_CMD;
        else if (grant_b) state_d = b_we ? S_B_WR : S_B_RD_CMD;
      end
      S_A_CMD:     if (!ddr.DDRAM_BUSY) state_d = S_A_DATA;
      S_A_DATA:    if (ddr.DDRAM_DOUT_READY && cnt_q == A_LAST) state_d = S_RELEASE;
      S_B_RD_CMD:  if (!ddr.DDRAM_BUSY) state_d = S_B_RD_DATA;
      S_B_RD_DATA: if (ddr.DDRAM_DOUT_READY) state_d = S_RELEASE;
      // we_q low means the write was accepted on the previous edge
      S_B_WR:      if (!we_q) state_d = S_RELEASE;
      S_RELEASE:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    we_d      = we_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    din_d     = din_q;
    be_d      = be_q;
    a_dout_d  = a_dout;
    b_dout_d  = b_dout;
    a_valid_d = 1'b0;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (grant_a) begin
          rd_d    = 1'b1;
          addr_d  = a_addr;
          burst_d = A_BURSTCNT;
        end else if (grant_b) begin
          rd_d    = !b_we;
          we_d    = b_we;
          addr_d  = b_addr;
          burst_d = BURST_W'(1);
          din_d   = b_din;
          be_d    = b_be;
        end
      end
      S_A_CMD, S_B_RD_CMD: if (!ddr.DDRAM_BUSY) rd_d = 1'b0;
      S_A_DATA: begin
        if (ddr.DDRAM_DOUT_READY) begin
          a_dout_d  = ddr.DDRAM_DOUT;
          a_valid_d = 1'b1;
          a_done_d  = (cnt_q == A_LAST);
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      S_B_RD_DATA: begin
        if (ddr.DDRAM_DOUT_READY) begin
          b_dout_d = ddr.DDRAM_DOUT;
          b_done_d = 1'b1;
        end
      end
      S_B_WR: begin
        if (we_q) begin
          if (!ddr.DDRAM_BUSY) we_d = 1'b0;
        end else begin
          b_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule
